// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory answering core loads/stores after LATENCY cycles.
module dmem_responder #(
  parameter int LATENCY = 1,
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        io_req_valid,
  output logic        io_req_ready,
  input  logic [31:0] io_req_bits_addr,
  input  logic [31:0] io_req_bits_data,
  input  logic        io_req_bits_fcn,
  input  logic [2:0]  io_req_bits_typ,
  output logic        io_resp_valid,
  output logic [31:0] io_resp_bits_data,
  output logic        io_resp_bits_err
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [1:0] cnt, cnt_nx;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] idx;
  logic [1:0] off;
  logic [2:0] typ;
  logic [31:0] word, load_data, wdata, rdata;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  logic [3:0] mask;
  logic accept, err, we, rerr;
  logic unused_addr;
  assign unused_addr = ^io_req_bits_addr[31:6];
  assign off = io_req_bits_addr[1:0];
  assign typ = io_req_bits_typ;
  assign idx = AW'(32'(io_req_bits_addr[5:2]) % DEPTH);
  assign word = mem[idx];
  assign byte_v = 8'(word >> {off, 3'b000});
  assign half_v = 16'(word >> {off[1], 4'b0000});
  assign io_req_ready = state == IDLE;
  assign accept = io_req_valid && io_req_ready;
  // typ[1:0]==1 covers both H and HU; typ[2] on a store covers BU/HU and the illegal 6/7
  assign err = typ == 3'd3 || typ[2:1] == 2'b11 || (typ[1:0] == 2'd1 && off[0]) ||
               (typ == 3'd2 && off != 2'd0) || (io_req_bits_fcn && typ[2]);
  assign we = accept && io_req_bits_fcn && !err;
  assign load_data = typ == 3'd0 ? {{24{byte_v[7]}}, byte_v} :
                     typ == 3'd1 ? {{16{half_v[15]}}, half_v} :
                     typ == 3'd4 ? {24'd0, byte_v} :
                     typ == 3'd5 ? {16'd0, half_v} : word;
  assign mask = typ == 3'd0 ? 4'b0001 << off : typ == 3'd1 ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
  assign wdata = typ == 3'd0 ? {4{io_req_bits_data[7:0]}} :
                 typ == 3'd1 ? {2{io_req_bits_data[15:0]}} : io_req_bits_data;
  assign io_resp_valid = state == RESP;
  assign io_resp_bits_data = io_resp_valid ? rdata : '0;
  assign io_resp_bits_err = io_resp_valid && rerr;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    case (state)
      IDLE: if (accept) begin
        state_nx = LATENCY == 1 ? RESP : WAIT;
        cnt_nx = 2'(LATENCY - 1);
      end
      WAIT: begin
        state_nx = cnt == 2'd1 ? RESP : WAIT;
        cnt_nx = cnt - 2'd1;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      rdata <= '0;
      rerr <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (accept) begin
        rdata <= (io_req_bits_fcn || err) ? '0 : load_data;
        rerr <= err;
      end
    end
  end
  // reset preloads each word with its own index nibble so loads are recognisable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= {8{i[3:0]}};
    end else if (we) begin
      for (int j = 0; j < 4; j++) if (mask[j]) mem[idx][8*j +: 8] <= wdata[8*j +: 8];
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and random checks of dmem_responder at LATENCY 1 and 3.
module tb_dmem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rn1, v1, f1, rdy1, rv1, re1;
  logic [31:0] a1, d1, rd1;
  logic [2:0] t1;
  logic rn3, v3, f3, rdy3, rv3, re3;
  logic [31:0] a3, d3, rd3;
  logic [2:0] t3;
  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [16];

  dmem_responder #(.LATENCY(1), .DEPTH(16)) dut1 (
    .clk(clk), .reset_n(rn1), .io_req_valid(v1), .io_req_ready(rdy1),
    .io_req_bits_addr(a1), .io_req_bits_data(d1), .io_req_bits_fcn(f1), .io_req_bits_typ(t1),
    .io_resp_valid(rv1), .io_resp_bits_data(rd1), .io_resp_bits_err(re1));

  dmem_responder #(.LATENCY(3), .DEPTH(16)) dut3 (
    .clk(clk), .reset_n(rn3), .io_req_valid(v3), .io_req_ready(rdy3),
    .io_req_bits_addr(a3), .io_req_bits_data(d3), .io_req_bits_fcn(f3), .io_req_bits_typ(t3),
    .io_resp_valid(rv3), .io_resp_bits_data(rd3), .io_resp_bits_err(re3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 16; i++) mdl[i] = 32'h11111111 * i;
  endtask

  // byte-level reference: access size bytes starting at offset o of word w
  task automatic mdl_op(input logic [31:0] a, input logic [31:0] d, input logic f,
                        input logic [2:0] t, output logic [31:0] rd, output logic re);
    int w, o, sz;
    w = int'(a[5:2]);
    o = int'(a[1:0]);
    sz = (t == 3'd0 || t == 3'd4) ? 1 : (t == 3'd1 || t == 3'd5) ? 2 : 4;
    re = (t == 3'd3 || t == 3'd6 || t == 3'd7) || (o % sz != 0) || (f && t >= 3'd4);
    rd = '0;
    if (re) return;
    if (f) begin
      for (int k = 0; k < sz; k++) mdl[w][8*(o+k) +: 8] = d[8*k +: 8];
    end else begin
      for (int k = 0; k < sz; k++) rd[8*k +: 8] = mdl[w][8*(o+k) +: 8];
      if (t < 3'd4 && sz < 4 && rd[8*sz-1])
        for (int k = sz; k < 4; k++) rd[8*k +: 8] = 8'hFF;
    end
  endtask

  task automatic txn1(input string tag, input logic [31:0] a, input logic [31:0] d, input logic f,
                      input logic [2:0] t, input bit fixed, input logic [31:0] xd, input logic xe);
    logic [31:0] md;
    logic me;
    mdl_op(a, d, f, t, md, me);
    if (fixed) begin
      md = xd;
      me = xe;
    end
    @(negedge clk);
    chk({tag, " idle_ready"}, 32'(rdy1), 32'd1);
    chk({tag, " idle_valid"}, 32'(rv1), 32'd0);
    v1 = 1'b1; a1 = a; d1 = d; f1 = f; t1 = t;
    @(posedge clk);
    #1 v1 = 1'b0; a1 = $urandom; d1 = $urandom; t1 = 3'($urandom_range(0, 7));
    @(negedge clk);
    chk({tag, " resp_valid"}, 32'(rv1), 32'd1);
    chk({tag, " resp_data"}, rd1, md);
    chk({tag, " resp_err"}, 32'(re1), 32'(me));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra;
    logic [2:0] rt;
    int acc;
    rn1 = 1'b0; rn3 = 1'b0;
    v1 = 1'b0; a1 = '0; d1 = '0; f1 = 1'b0; t1 = '0;
    v3 = 1'b0; a3 = '0; d3 = '0; f3 = 1'b0; t3 = '0;
    mdl_reset();
    repeat (2) @(negedge clk);
    chk("rst valid1", 32'(rv1), 32'd0);
    chk("rst data1", rd1, 32'd0);
    chk("rst err1", 32'(re1), 32'd0);
    chk("rst valid3", 32'(rv3), 32'd0);
    rn1 = 1'b1; rn3 = 1'b1;
    @(negedge clk);
    chk("post_rst ready1", 32'(rdy1), 32'd1);
    chk("post_rst ready3", 32'(rdy3), 32'd1);

    txn1("lw_14", 32'h14, 32'h0, 1'b0, 3'd2, 1, 32'h55555555, 1'b0);
    txn1("sb_09", 32'h09, 32'hAB, 1'b1, 3'd0, 1, 32'h0, 1'b0);
    txn1("lw_08", 32'h08, 32'h0, 1'b0, 3'd2, 1, 32'h2222AB22, 1'b0);
    txn1("lb_3b", 32'h3B, 32'h0, 1'b0, 3'd0, 1, 32'hFFFFFFEE, 1'b0);
    txn1("lbu_3b", 32'h3B, 32'h0, 1'b0, 3'd4, 1, 32'h000000EE, 1'b0);
    txn1("lw_44", 32'h44, 32'h0, 1'b0, 3'd2, 1, 32'h11111111, 1'b0);
    txn1("lh_41", 32'h41, 32'h0, 1'b0, 3'd1, 1, 32'h0, 1'b1);
    txn1("sw_06", 32'h06, 32'hCAFEF00D, 1'b1, 3'd2, 1, 32'h0, 1'b1);
    txn1("lw_04", 32'h04, 32'h0, 1'b0, 3'd2, 1, 32'h11111111, 1'b0);
    txn1("sh_7a", 32'h7A, 32'h1234BEEF, 1'b1, 3'd1, 1, 32'h0, 1'b0);
    txn1("lhu_3a", 32'h3A, 32'h0, 1'b0, 3'd5, 1, 32'h0000BEEF, 1'b0);
    txn1("lh_3a", 32'h3A, 32'h0, 1'b0, 3'd1, 1, 32'hFFFFBEEF, 1'b0);
    txn1("sbu_00", 32'h00, 32'h55, 1'b1, 3'd4, 1, 32'h0, 1'b1);

    for (int n = 0; n < 80; n++) begin
      ra = $urandom;
      rt = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) ra[1:0] = 2'b00;
      txn1($sformatf("rnd%0d", n), ra, $urandom, 1'($urandom_range(0, 1)), rt, 0, 32'h0, 1'b0);
    end

    // LATENCY 3: request held valid for 10 cycles
    acc = 0;
    a3 = 32'h14; f3 = 1'b0; t3 = 3'd2;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      v3 = k < 10;
      chk($sformatf("l3 ready k%0d", k), 32'(rdy3), 32'(k % 4 == 0));
      chk($sformatf("l3 valid k%0d", k), 32'(rv3), 32'(k % 4 == 3));
      if (k % 4 == 3) begin
        chk($sformatf("l3 data k%0d", k), rd3, 32'h55555555);
        chk($sformatf("l3 err k%0d", k), 32'(re3), 32'd0);
      end
      if (v3 && rdy3) acc++;
    end
    v3 = 1'b0;
    chk("l3 acceptances", 32'(acc), 32'd3);

    // reset mid-flight after a store
    @(negedge clk);
    v3 = 1'b1; a3 = 32'h0; d3 = 32'hDEADBEEF; f3 = 1'b1; t3 = 3'd2;
    @(posedge clk);
    #1 v3 = 1'b0;
    @(negedge clk);
    chk("midrst in_wait", 32'(rdy3), 32'd0);
    rn3 = 1'b0;
    #1;
    chk("midrst valid", 32'(rv3), 32'd0);
    chk("midrst data", rd3, 32'd0);
    chk("midrst err", 32'(re3), 32'd0);
    chk("midrst ready", 32'(rdy3), 32'd1);
    @(negedge clk);
    rn3 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("postrst no_resp k%0d", k), 32'(rv3), 32'd0);
      chk($sformatf("postrst ready k%0d", k), 32'(rdy3), 32'd1);
    end
    v3 = 1'b1; a3 = 32'h0; f3 = 1'b0; t3 = 3'd2;
    @(posedge clk);
    #1 v3 = 1'b0;
    repeat (3) @(negedge clk);
    chk("postrst lw0 valid", 32'(rv3), 32'd1);
    chk("postrst lw0 data", rd3, 32'h00000000);
    chk("postrst lw0 err", 32'(re3), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
